pulse_width_meter: RTL and testbench

//  Downstream consumer of the 555-timer pulse output. Synchronises the incoming

---
 rtl/pulse_meas_pkg.sv | 19 +
 rtl/sync_edge_detect.sv | 40 ++++
 rtl/pulse_width_meter.sv | 129 ++++++++++++
 tb/tb_pulse_width_meter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meas_pkg.sv
// rtl/pulse_meas_pkg.sv - shared types and helpers for the pulse width meter
package pulse_meas_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } meas_state_t;

    // All-ones value of a w-bit counter, usable for any counter width up to 32
    function automatic logic [31:0] SAT_VAL(input int unsigned w);
        if (w >= 32)
            SAT_VAL = '1;
        else
            SAT_VAL = (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-stage synchroniser with rise/fall detection
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic s_cur,
    output logic s_prev,
    output logic rise,
    output logic fall,
    output logic primed
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] fill_q;

    // Synchroniser chain, one-cycle history, and a fill marker that shows when
    // s_cur reflects the real input rather than the reset value of the chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            s_prev <= 1'b0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            s_prev <= s_cur;
            fill_q <= {fill_q[STAGES-2:0], 1'b1};
        end
    end

    // Edge decode from the synchronised level and its one-cycle history
    always_comb begin
        s_cur  = sync_q[STAGES-1];
        rise   = s_cur & ~s_prev;
        fall   = ~s_cur & s_prev;
        primed = fill_q[STAGES-1];
    end

endmodule

// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - measures high/low/period of a pulse train in clk cycles
module pulse_width_meter
    import pulse_meas_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] on_count,
    output logic [CNT_W-1:0] off_count,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             overflow,
    output logic             busy
);

    localparam logic [31:0]      SAT_FULL = SAT_VAL(CNT_W);
    localparam logic [CNT_W-1:0] SAT      = SAT_FULL[CNT_W-1:0];

    meas_state_t      state, next_state;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] hi_lat;
    logic             s_cur, s_prev, rise, fall, primed;
    logic             any_edge;
    logic             latch_hi;
    logic             report;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pulse_in),
        .s_cur   (s_cur),
        .s_prev  (s_prev),
        .rise    (rise),
        .fall    (fall),
        .primed  (primed)
    );

    assign any_edge = rise | fall;

    // State register; clear restarts the measurement from IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else if (clear)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next state: IDLE waits for a genuine low so a partial high phase is never measured
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (primed && !s_cur) next_state = ARMED;
            ARMED:     if (rise)             next_state = MEAS_HIGH;
            MEAS_HIGH: if (fall)             next_state = MEAS_LOW;
            MEAS_LOW:  if (rise)             next_state = MEAS_HIGH;
            default:                         next_state = IDLE;
        endcase
    end

    // Per-state actions: capture the high run, or report a completed cycle
    always_comb begin
        busy     = (state == MEAS_HIGH) || (state == MEAS_LOW);
        latch_hi = (state == MEAS_HIGH) && fall;
        report   = (state == MEAS_LOW) && rise;
    end

    // Run-length counter restarted on every edge, saturating at all-ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            run_cnt <= '0;
        else if (clear)
            run_cnt <= '0;
        else if (any_edge)
            run_cnt <= CNT_W'(1);
        else if (run_cnt != SAT)
            run_cnt <= run_cnt + CNT_W'(1);
    end

    // Sticky overflow when a measured run reaches saturation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (clear)
            overflow <= 1'b0;
        else if (busy && !any_edge && (run_cnt == SAT - CNT_W'(1)))
            overflow <= 1'b1;
    end

    // Holds the high-phase length until the closing rise reports it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hi_lat <= '0;
        else if (clear)
            hi_lat <= '0;
        else if (latch_hi)
            hi_lat <= run_cnt;
    end

    // Registered results and one-cycle valid strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            on_count   <= '0;
            off_count  <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
        end else if (clear) begin
            on_count   <= '0;
            off_count  <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= report;
            if (report) begin
                on_count  <= hi_lat;
                off_count <= run_cnt;
                period    <= {1'b0, hi_lat} + {1'b0, run_cnt};
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - directed self-checking bench for pulse_width_meter
module tb_pulse_width_meter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        pulse_in;

    logic [15:0] on16, off16;
    logic [16:0] per16;
    logic        mv16, ovf16, busy16;
    logic [3:0]  on4, off4;
    logic [4:0]  per4;
    logic        mv4, ovf4, busy4;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int q_on[$], q_off[$], q_per[$], q_cyc[$];
    int r_on[$], r_off[$], r_per[$];
    int vr16 = 0, maxw16 = 0;
    int vr4  = 0, maxw4  = 0;

    pulse_width_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut16 (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .pulse_in   (pulse_in),
        .on_count   (on16),
        .off_count  (off16),
        .period     (per16),
        .meas_valid (mv16),
        .overflow   (ovf16),
        .busy       (busy16)
    );

    pulse_width_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .pulse_in   (pulse_in),
        .on_count   (on4),
        .off_count  (off4),
        .period     (per4),
        .meas_valid (mv4),
        .overflow   (ovf4),
        .busy       (busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mv16) begin
            q_on.push_back(int'(on16));
            q_off.push_back(int'(off16));
            q_per.push_back(int'(per16));
            q_cyc.push_back(cyc);
            vr16 <= vr16 + 1;
            if (vr16 + 1 > maxw16) maxw16 <= vr16 + 1;
        end else begin
            vr16 <= 0;
        end
        if (mv4) begin
            r_on.push_back(int'(on4));
            r_off.push_back(int'(off4));
            r_per.push_back(int'(per4));
            vr4 <= vr4 + 1;
            if (vr4 + 1 > maxw4) maxw4 <= vr4 + 1;
        end else begin
            vr4 <= 0;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic do_reset(input logic lvl);
        reset_n  = 1'b0;
        clear    = 1'b0;
        pulse_in = lvl;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic step(input logic lvl, input int n);
        pulse_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Checks n consecutive 16-bit reports from index start, incl. strobe spacing
    task automatic chk16(input string tag, input int start, input int n, input int on, input int off);
        for (int i = start; i < start + n; i++) begin
            if (i < q_on.size()) begin
                chk({tag, "_on"},  q_on[i],  on);
                chk({tag, "_off"}, q_off[i], off);
                chk({tag, "_per"}, q_per[i], on + off);
                if (i > start) chk({tag, "_gap"}, q_cyc[i] - q_cyc[i-1], on + off);
            end
        end
    endtask

    task automatic chk4(input string tag, input int idx, input int on, input int off, input int per);
        if (idx < r_on.size()) begin
            chk({tag, "_on"},  r_on[idx],  on);
            chk({tag, "_off"}, r_off[idx], off);
            chk({tag, "_per"}, r_per[idx], per);
        end
    endtask

    initial begin
        int b16, b4;

        // Reset state and steady 5/3 pulse train
        do_reset(1'b0);
        chk("rst_on",   int'(on16), 0);
        chk("rst_off",  int'(off16), 0);
        chk("rst_per",  int'(per16), 0);
        chk("rst_mv",   int'(mv16), 0);
        chk("rst_ovf",  int'(ovf16), 0);
        chk("rst_busy", int'(busy16), 0);
        chk("rst_on4",  int'(on4), 0);
        b16 = q_on.size();
        step(1'b0, 6);
        step(1'b1, 5);
        chk("t1_busy", int'(busy16), 1);
        step(1'b0, 3);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 5);
            step(1'b0, 3);
        end
        step(1'b1, 2);
        step(1'b0, 6);
        chk("t1_count", q_on.size() - b16, 4);
        chk16("t1", b16, 4, 5, 3);

        // Partial high phase at reset release is discarded
        do_reset(1'b1);
        b16 = q_on.size();
        step(1'b1, 10);
        chk("t2_idle_busy", int'(busy16), 0);
        step(1'b0, 4);
        step(1'b1, 6);
        step(1'b0, 4);
        step(1'b1, 3);
        step(1'b0, 6);
        chk("t2_count", q_on.size() - b16, 1);
        chk16("t2", b16, 1, 6, 4);

        // Saturation on the 4-bit instance, overflow sticky
        do_reset(1'b0);
        b16 = q_on.size();
        b4  = r_on.size();
        step(1'b0, 4);
        step(1'b1, 20);
        step(1'b0, 2);
        step(1'b1, 5);
        step(1'b0, 3);
        step(1'b1, 2);
        step(1'b0, 6);
        chk("t3_count4", r_on.size() - b4, 2);
        chk4("t3_sat", b4, 15, 2, 17);
        chk4("t3_norm", b4 + 1, 5, 3, 8);
        chk("t3_ovf4", int'(ovf4), 1);
        chk("t3_count16", q_on.size() - b16, 2);
        chk16("t3_a", b16, 1, 20, 2);
        chk16("t3_b", b16 + 1, 1, 5, 3);
        chk("t3_ovf16", int'(ovf16), 0);

        // Clear on the same cycle as the closing rise
        do_reset(1'b0);
        b16 = q_on.size();
        b4  = r_on.size();
        step(1'b0, 4);
        step(1'b1, 20);
        step(1'b0, 3);
        step(1'b1, 5);
        step(1'b0, 3);
        chk("t4_pre_on", int'(on16), 20);
        chk("t4_pre_ovf4", int'(ovf4), 1);
        pulse_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        chk("t4_clr_on",   int'(on16), 0);
        chk("t4_clr_off",  int'(off16), 0);
        chk("t4_clr_per",  int'(per16), 0);
        chk("t4_clr_ovf4", int'(ovf4), 0);
        chk("t4_clr_busy", int'(busy16), 0);
        step(1'b1, 3);
        chk("t4_no_strobe", q_on.size() - b16, 1);
        step(1'b0, 3);
        step(1'b1, 5);
        step(1'b0, 3);
        step(1'b1, 2);
        step(1'b0, 6);
        chk("t4_count", q_on.size() - b16, 2);
        chk16("t4_first", b16, 1, 20, 3);
        chk16("t4_recov", b16 + 1, 1, 5, 3);
        chk("t4_ovf4_end", int'(ovf4), 0);

        // Asynchronous reset in the middle of a high phase
        do_reset(1'b0);
        b16 = q_on.size();
        step(1'b0, 4);
        step(1'b1, 5);
        step(1'b0, 3);
        step(1'b1, 5);
        step(1'b0, 3);
        step(1'b1, 4);
        chk("t5_pre_count", q_on.size() - b16, 2);
        chk("t5_pre_on", int'(on16), 5);
        chk("t5_pre_busy", int'(busy16), 1);
        #3 reset_n = 1'b0;
        #1;
        chk("t5_ar_on",   int'(on16), 0);
        chk("t5_ar_off",  int'(off16), 0);
        chk("t5_ar_per",  int'(per16), 0);
        chk("t5_ar_busy", int'(busy16), 0);
        chk("t5_ar_mv",   int'(mv16), 0);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        b16 = q_on.size();
        step(1'b1, 3);
        step(1'b0, 3);
        step(1'b1, 5);
        step(1'b0, 3);
        step(1'b1, 5);
        step(1'b0, 3);
        step(1'b1, 2);
        step(1'b0, 6);
        chk("t5_count", q_on.size() - b16, 2);
        chk16("t5", b16, 2, 5, 3);

        // Timer-like 7/13 waveform over five periods, then minimum 1/1 pulses
        do_reset(1'b0);
        b16 = q_on.size();
        step(1'b0, 4);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 7);
            step(1'b0, 13);
        end
        step(1'b1, 1);
        step(1'b0, 1);
        step(1'b1, 1);
        step(1'b0, 1);
        step(1'b1, 2);
        step(1'b0, 6);
        chk("t6_count", q_on.size() - b16, 7);
        chk16("t6_timer", b16, 5, 7, 13);
        chk16("t6_min", b16 + 5, 2, 1, 1);

        chk("strobe_width16", maxw16, 1);
        chk("strobe_width4",  maxw4, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
